// File: rtl/bufg_gt_pkg.sv
// Shared types and constants for the BUFG_GT divide-change sequencer.
package bufg_gt_pkg;

  localparam int unsigned DIV_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    CE_OFF = 2'd0,
    CLR_ON = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_e;

  // Wait lengths must fit the 8-bit down-counter; the divide code must fit DIV_W.
  function automatic bit params_legal(input int unsigned init_div,
                                      input int unsigned ce_off_cyc,
                                      input int unsigned clr_cyc,
                                      input int unsigned settle_cyc);
    return (init_div < (32'd1 << DIV_W)) &&
           (ce_off_cyc >= 32'd1) && (ce_off_cyc <= 32'd256) &&
           (clr_cyc    >= 32'd1) && (clr_cyc    <= 32'd256) &&
           (settle_cyc >= 32'd1) && (settle_cyc <= 32'd256);
  endfunction

endpackage

// File: rtl/bufg_gt_div_seq.sv
// Glitch-safe DIV/CE/CLR sequencer for a BUFG_GT clock buffer.
// Optional BUFG_GT_DIV_SEQ_SKIP_SAME_EN: a request for the current code completes without a sequence.
module bufg_gt_div_seq
  import bufg_gt_pkg::*;
#(
  parameter int unsigned INIT_DIV   = 0,
  parameter int unsigned CE_OFF_CYC = 4,
  parameter int unsigned CLR_CYC    = 3,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             req_vld,
  input  logic [DIV_W-1:0] req_div,
  output logic             req_rdy,
  output logic [DIV_W-1:0] bg_div,
  output logic             bg_ce,
  output logic             bg_clr,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] INIT_DIV_C = DIV_W'(INIT_DIV);
  localparam logic [CNT_W-1:0] CE_OFF_LD  = CNT_W'(CE_OFF_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CLR_LD     = CNT_W'(CLR_CYC - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 32'd1);

  if (!params_legal(INIT_DIV, CE_OFF_CYC, CLR_CYC, SETTLE_CYC)) begin : g_param_err
    $error("bufg_gt_div_seq: illegal parameter set");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] lat_q, lat_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic             clr_q, clr_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             same_c;

  // State and output registers; CLR forces the power-up sequence mid-flight.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= CLR_ON;
      cnt_q   <= CLR_LD;
      lat_q   <= INIT_DIV_C;
      div_q   <= INIT_DIV_C;
      ce_q    <= 1'b0;
      clr_q   <= 1'b1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      div_q   <= div_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: each wait state counts down from PARAM-1 and leaves on cnt==0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    div_d   = div_q;
    ce_d    = ce_q;
    clr_d   = clr_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    same_c  = 1'b0;
`ifdef BUFG_GT_DIV_SEQ_SKIP_SAME_EN
    same_c  = (req_div == div_q);
`endif

    unique case (state_q)
      RUN: begin
        if (req_vld && rdy_q) begin
          if (same_c) begin
            done_d = 1'b1;
          end else begin
            lat_d   = req_div;
            ce_d    = 1'b0;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = CE_OFF_LD;
            state_d = CE_OFF;
          end
        end
      end
      CE_OFF: begin
        if (cnt_q == '0) begin
          clr_d   = 1'b1;
          div_d   = lat_q;
          cnt_d   = CLR_LD;
          state_d = CLR_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLR_ON: begin
        if (cnt_q == '0) begin
          clr_d   = 1'b0;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          ce_d    = 1'b1;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign req_rdy = rdy_q;
  assign bg_div  = div_q;
  assign bg_ce   = ce_q;
  assign bg_clr  = clr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bufg_gt_div_seq.sv
// Scoreboard bench for bufg_gt_div_seq: expected completions are queued at accept/reset release.
module tb_bufg_gt_div_seq;

  localparam int INIT   = 1;
  localparam int T_CE   = 4;
  localparam int T_CLR  = 3;
  localparam int T_SET  = 4;
`ifdef BUFG_GT_DIV_SEQ_SKIP_SAME_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] div;
    int         done_cyc;
    int         rise_cyc;
    int         fall_cyc;
    bit         skip;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       req_vld = 1'b0;
  logic [2:0] req_div = 3'd0;
  logic       req_rdy;
  logic [2:0] bg_div;
  logic       bg_ce;
  logic       bg_clr;
  logic       busy;
  logic       done;

  bufg_gt_div_seq #(
    .INIT_DIV  (INIT),
    .CE_OFF_CYC(T_CE),
    .CLR_CYC   (T_CLR),
    .SETTLE_CYC(T_SET)
  ) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .req_vld(req_vld),
    .req_div(req_div),
    .req_rdy(req_rdy),
    .bg_div (bg_div),
    .bg_ce  (bg_ce),
    .bg_clr (bg_clr),
    .busy   (busy),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  exp_t sb[$];
  exp_t me;
  bit   m_idle = 1'b0;
  logic [2:0] m_div = 3'(INIT);
  bit   in_rst = 1'b0;
  logic prev_clr = 1'b1;
  logic [2:0] prev_div = 3'(INIT);
  logic prev_done = 1'b0;
  int   last_rise = -1;
  int   last_fall = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each done pulse.
  always @(negedge CLK) begin
    if (CLR) begin
      chk("rst_clr", int'(bg_clr), 1);
      chk("rst_ce", int'(bg_ce), 0);
      chk("rst_div", int'(bg_div), INIT);
      chk("rst_rdy", int'(req_rdy), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_done", int'(done), 0);
      sb.delete();
      m_idle    = 1'b0;
      m_div     = 3'(INIT);
      in_rst    = 1'b1;
      prev_clr  = 1'b1;
      prev_div  = 3'(INIT);
      prev_done = 1'b0;
    end else begin
      if (in_rst) begin
        me.div      = 3'(INIT);
        me.rise_cyc = -1;
        me.fall_cyc = cyc + T_CLR;
        me.done_cyc = cyc + T_CLR + T_SET;
        me.skip     = 1'b0;
        sb.push_back(me);
        in_rst = 1'b0;
      end
      chk("ce_clr_excl", int'(bg_ce & bg_clr), 0);
      if (bg_div !== prev_div) chk("div_chg_clr", int'(bg_clr), 1);
      if (prev_done) chk("done_width", int'(done), 0);
      if (bg_clr && !prev_clr) last_rise = cyc;
      if (!bg_clr && prev_clr) last_fall = cyc;

      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexp", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("done_cyc", cyc, me.done_cyc);
          chk("done_div", int'(bg_div), int'(me.div));
          chk("done_ce", int'(bg_ce), 1);
          chk("done_clr", int'(bg_clr), 0);
          if (!me.skip) begin
            chk("clr_fall", last_fall, me.fall_cyc);
            if (me.rise_cyc >= 0) chk("clr_rise", last_rise, me.rise_cyc);
          end
          m_idle = 1'b1;
          m_div  = me.div;
        end
      end
      if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        chk("done_missing", cyc, sb[0].done_cyc);
        me = sb.pop_front();
        m_idle = 1'b1;
        m_div  = me.div;
      end

      chk("rdy", int'(req_rdy), int'(m_idle));
      chk("busy", int'(busy), int'(!m_idle));

      if (req_vld && req_rdy) begin
        n_acc++;
        me.div  = req_div;
        me.skip = SKIP_EN && (req_div == m_div);
        if (me.skip) begin
          me.done_cyc = cyc + 1;
          me.rise_cyc = -1;
          me.fall_cyc = -1;
        end else begin
          me.rise_cyc = cyc + 1 + T_CE;
          me.fall_cyc = cyc + 1 + T_CE + T_CLR;
          me.done_cyc = cyc + 1 + T_CE + T_CLR + T_SET;
          m_idle = 1'b0;
        end
        sb.push_back(me);
      end
      prev_clr  = bg_clr;
      prev_div  = bg_div;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_accept();
    int start;
    start = n_acc;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (n_acc != start) break;
    end
    chk("accept_seen", int'(n_acc != start), 1);
  endtask

  task automatic issue(input logic [2:0] d);
    req_div = d;
    req_vld = 1'b1;
    wait_accept();
    req_vld = 1'b0;
  endtask

  task automatic issue_pair(input logic [2:0] d1, input logic [2:0] d2);
    req_div = d1;
    req_vld = 1'b1;
    wait_accept();
    req_div = d2;
    wait_accept();
    req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (m_idle && sb.size() == 0) break;
      tick();
    end
    chk("idle_reached", int'(m_idle && sb.size() == 0), 1);
  endtask

  initial begin
    bit saw6;
    logic [2:0] d;
    #1 CLR = 1'b1;
    repeat (5) @(posedge CLK);
    #2 CLR = 1'b0;
    wait_idle();
    chk("post_rst_div", int'(bg_div), INIT);

    issue(3'd5);
    wait_idle();

    issue_pair(3'd7, 3'd2);
    wait_idle();
    chk("pair_final_div", int'(bg_div), 2);

    // CLR lands before the new code reaches bg_div; it must never appear.
    issue(3'd6);
    repeat (2) @(posedge CLK);
    #2 CLR = 1'b1;
    saw6 = 1'b0;
    tick();
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bg_div == 3'd6) saw6 = 1'b1;
      tick();
    end
    chk("div_never_6", int'(saw6), 0);
    wait_idle();
    chk("div_after_clr", int'(bg_div), INIT);

    issue(3'd4);
    wait_idle();
    issue(3'd4);
    wait_idle();

    for (int n = 0; n < 16; n++) begin
      d = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) d = m_div;
      repeat ($urandom_range(0, 2)) tick();
      issue(d);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
